// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch stage.
package fetch_pkg;

  localparam int              XLEN             = 32;
  localparam logic [XLEN-1:0] RESET_PC_DEFAULT = 32'h0000_0000;
  localparam logic [XLEN-1:0] INSTR_NOP        = 32'h0000_0013;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] instr;
  } fetch_entry_t;

  // Instruction memory is word-indexed; the low two PC bits never reach it.
  function automatic logic [XLEN-1:0] word_index(input logic [XLEN-1:0] byte_pc);
    return {2'b00, byte_pc[XLEN-1:2]};
  endfunction

endpackage

// File: rtl/fetch_fifo.sv
// Small flushable FIFO of fetch entries; entry 0 is always the head, so the
// head outputs come straight from a register.
module fetch_fifo
  import fetch_pkg::*;
#(
  parameter  int DEPTH = 2,
  localparam int CW    = $clog2(DEPTH + 1)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          enq,
  input  fetch_entry_t  enq_data,
  input  logic          deq,
  input  logic          flush,
  output logic [CW-1:0] count,
  output logic          head_valid,
  output fetch_entry_t  head
);

  fetch_entry_t  mem_q [DEPTH];
  fetch_entry_t  mem_d [DEPTH];
  logic [CW-1:0] count_d;
  logic [CW-1:0] fill;

  // NOTE: every always_comb output gets a default first, so no latch can be inferred.
  always_comb begin
    mem_d = mem_q;
    fill  = count;
    if (deq && count != '0) begin
      for (int i = 0; i < DEPTH - 1; i++) mem_d[i] = mem_q[i+1];
      fill = count - CW'(1);
    end
    count_d = fill;
    if (enq && fill < CW'(DEPTH)) begin
      for (int i = 0; i < DEPTH; i++) begin
        if (CW'(i) == fill) mem_d[i] = enq_data;
      end
      count_d = fill + CW'(1);
    end
    if (flush) count_d = '0;
  end

  // NOTE: sequential state uses non-blocking assignments only.
  always_ff @(posedge clk) begin
    if (reset) count <= '0;
    else       count <= count_d;
  end

  // NOTE: storage is deliberately not reset; count gates it, and the top masks
  // head data whenever head_valid is low.
  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

  assign head       = mem_q[0];
  assign head_valid = (count != '0);

endmodule

// File: rtl/pc_fetch_unit.sv
// Fetch stage: owns the PC, reads the single-cycle instruction memory and
// hands {pc, instr} to decode through a small flushable buffer.
module pc_fetch_unit
  import fetch_pkg::*;
#(
  parameter logic [XLEN-1:0] RESET_PC   = RESET_PC_DEFAULT,
  parameter int              IMEM_WORDS = 1025,
  parameter int              BUF_DEPTH  = 2
) (
  input  logic            clk,
  input  logic            reset,
  output logic [XLEN-1:0] imem_addr,
  input  logic [XLEN-1:0] imem_instr,
  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_target,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] out_instr,
  output logic [XLEN-1:0] out_pc,
  output logic [XLEN-1:0] out_pc_plus4,
  output logic            fetch_fault
);

  localparam int CW = $clog2(BUF_DEPTH + 1);

  logic [XLEN-1:0] pc;
  logic [CW-1:0]   count;
  logic            head_valid;
  fetch_entry_t    head;
  fetch_entry_t    fetched;
  logic            deq;
  logic            buf_open;
  logic            would_fetch;
  logic            in_range;
  logic            do_fetch;
  logic            redirect_take;
  logic            misaligned;

  assign imem_addr     = word_index(pc);
  assign in_range      = imem_addr < XLEN'(IMEM_WORDS);
  assign deq           = out_valid && out_ready;
  // A full buffer still accepts a fetch when the head leaves this cycle.
  assign buf_open      = (count < CW'(BUF_DEPTH)) || deq;
  assign would_fetch   = !reset && !fetch_fault && !redirect_valid && buf_open;
  assign do_fetch      = would_fetch && in_range;
  assign redirect_take = redirect_valid && !fetch_fault;
  assign misaligned    = redirect_target[1:0] != 2'b00;
  assign fetched       = '{pc: pc, instr: imem_instr};

  always_ff @(posedge clk) begin
    if (reset) begin
      pc          <= RESET_PC;
      fetch_fault <= 1'b0;
    end else if (redirect_take) begin
      pc <= redirect_target;
      if (misaligned) fetch_fault <= 1'b1;
    end else if (do_fetch) begin
      pc <= pc + XLEN'(4);
    end else if (would_fetch) begin
      // Out-of-range fetch attempt: freeze here, keep draining the buffer.
      fetch_fault <= 1'b1;
    end
  end

  fetch_fifo #(
    .DEPTH (BUF_DEPTH)
  ) u_fifo (
    .clk        (clk),
    .reset      (reset),
    .enq        (do_fetch),
    .enq_data   (fetched),
    .deq        (deq),
    .flush      (redirect_take),
    .count      (count),
    .head_valid (head_valid),
    .head       (head)
  );

  assign out_valid    = head_valid && !reset;
  assign out_instr    = out_valid ? head.instr : '0;
  assign out_pc       = out_valid ? head.pc : '0;
  assign out_pc_plus4 = out_valid ? head.pc + XLEN'(4) : '0;

endmodule
